// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and limits for the data memory arbiter and its round-robin picker.
// Request fields are carried at the widest supported width and cast at the top level.
package data_mem_arbiter_pkg;

  localparam int MEM_LATENCY_MAX = 4;
  localparam int ADDR_WIDTH_MAX  = 32;
  localparam int DATA_WIDTH_MAX  = 32;

  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_MAX-1:0] addr;
    logic [DATA_WIDTH_MAX-1:0] wdata;
    logic [2:0]                funct3;
  } mem_req_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone valid port wins outright,
// and under contention the port that was not granted last wins.
module rr_arb2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (enable) begin
      case (valid)
        2'b01: begin
          grant     = 2'b01;
          grant_idx = 1'b0;
        end
        2'b10: begin
          grant     = 2'b10;
          grant_idx = 1'b1;
        end
        2'b11: begin
          grant_idx = ~last_grant;
          grant     = onehot2(~last_grant);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data memory between the core (port 0) and an external master (port 1),
// keeping at most one transaction outstanding and returning it after MEM_LATENCY cycles.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [5:0]              req_funct3_i,
  output logic [1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [2:0]              mem_funct3_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int CNT_WIDTH = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(MEM_LATENCY - 1);

  arb_state_t           state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic                 owner, owner_n;
  logic                 owner_we, owner_we_n;
  logic                 last_grant, last_grant_n;

  logic       accept_window;
  logic       response;
  logic [1:0] grant;
  logic       grant_idx;
  logic       granted;
  mem_req_t   req [2];
  mem_req_t   sel;

  // The response cycle doubles as an accept window so back-to-back traffic sees no bubble.
  assign accept_window = (state == ARB_IDLE) || (cnt == '0);
  assign response      = (state == ARB_WAIT) && (cnt == '0);

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid_i),
    .last_grant (last_grant),
    .enable     (accept_window && !rst),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign granted = |grant;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req[p].we     = req_we_i[p];
      req[p].addr   = ADDR_WIDTH_MAX'(req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
      req[p].wdata  = DATA_WIDTH_MAX'(req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH]);
      req[p].funct3 = req_funct3_i[p*3 +: 3];
    end
    sel = granted ? req[grant_idx] : '0;
  end

  assign req_ready_o  = grant;
  assign mem_en_o     = granted;
  assign mem_we_o     = sel.we;
  assign mem_addr_o   = ADDR_WIDTH'(sel.addr);
  assign mem_wdata_o  = DATA_WIDTH'(sel.wdata);
  assign mem_funct3_o = sel.funct3;

  // Writes are acknowledged too, but carry no read data back.
  assign rsp_valid_o = response ? onehot2(owner) : 2'b00;
  assign rsp_rdata_o = (response && !owner_we) ? mem_rdata_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      owner_we   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      owner      <= owner_n;
      owner_we   <= owner_we_n;
      last_grant <= last_grant_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    owner_n      = owner;
    owner_we_n   = owner_we;
    last_grant_n = last_grant;
    if (granted) begin
      state_n      = ARB_WAIT;
      cnt_n        = CNT_RELOAD;
      owner_n      = grant_idx;
      owner_we_n   = sel.we;
      last_grant_n = grant_idx;
    end else if (state == ARB_WAIT) begin
      if (cnt != '0) begin
        cnt_n = cnt - CNT_WIDTH'(1);
      end else begin
        state_n = ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: three instances with MEM_LATENCY 1, 2 and 3,
// each backed by a small behavioural memory.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          num_checks = 0;
  int          num_fails  = 0;

  logic [1:0]  req_valid  [3];
  logic [1:0]  req_ready  [3];
  logic [1:0]  req_we     [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic [5:0]  req_funct3 [3];
  logic [1:0]  rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        mem_en     [3];
  logic        mem_we     [3];
  logic [31:0] mem_addr   [3];
  logic [31:0] mem_wdata  [3];
  logic [2:0]  mem_funct3 [3];
  logic [31:0] mem_rdata  [3];

  logic [31:0] exp_data_q [6][$];
  int          exp_cyc_q  [6][$];

  logic [1:0]  last_ready;
  logic        last_mem_en;
  logic [31:0] last_mem_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] addr);
    return (addr == 32'h10) ? 32'hDEADBEEF : {8'hA5, 24'(addr[31:2])};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] mem [64];
    logic [63:0] written;
    logic [31:0] pdata;

    data_mem_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .MEM_LATENCY (g + 1)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid[g]),
      .req_ready_o  (req_ready[g]),
      .req_we_i     (req_we[g]),
      .req_addr_i   (req_addr[g]),
      .req_wdata_i  (req_wdata[g]),
      .req_funct3_i (req_funct3[g]),
      .rsp_valid_o  (rsp_valid[g]),
      .rsp_rdata_o  (rsp_rdata[g]),
      .mem_en_o     (mem_en[g]),
      .mem_we_o     (mem_we[g]),
      .mem_addr_o   (mem_addr[g]),
      .mem_wdata_o  (mem_wdata[g]),
      .mem_funct3_o (mem_funct3[g]),
      .mem_rdata_i  (mem_rdata[g])
    );

    // Only one access is ever outstanding, so a single read-data register models the latency.
    always @(posedge clk) begin
      if (rst) begin
        written <= '0;
      end else if (mem_en[g]) begin
        if (mem_we[g]) begin
          mem[mem_addr[g][7:2]]     <= mem_wdata[g];
          written[mem_addr[g][7:2]] <= 1'b1;
        end else begin
          pdata <= written[mem_addr[g][7:2]] ? mem[mem_addr[g][7:2]] : init_word(mem_addr[g]);
        end
      end
    end

    assign mem_rdata[g] = pdata;
  end

  // Monitor: every response pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    logic [31:0] d;
    int          c;
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        for (int p = 0; p < 2; p++) begin
          if (rsp_valid[g][p]) begin
            num_checks++;
            if (exp_data_q[g*2+p].size() == 0 || exp_cyc_q[g*2+p].size() == 0) begin
              num_fails++;
              $display("[TB] FAIL rsp_unexpected inst%0d port%0d: got rdata 0x%0h at cycle %0d, required no response",
                       g, p, rsp_rdata[g], cyc);
            end else begin
              d = exp_data_q[g*2+p].pop_front();
              c = exp_cyc_q[g*2+p].pop_front();
              if (rsp_rdata[g] !== d || cyc != c) begin
                num_fails++;
                $display("[TB] FAIL rsp inst%0d port%0d: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                         g, p, rsp_rdata[g], cyc, d, c);
              end
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Raises a request and holds it until accepted; returns just after the following negedge.
  task automatic applyStimulus(input int g, input int p, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp);
    bit accepted;
    accepted = 1'b0;
    req_valid[g][p]          = 1'b1;
    req_we[g][p]             = we;
    req_addr[g][p*32 +: 32]  = addr;
    req_wdata[g][p*32 +: 32] = wdata;
    req_funct3[g][p*3 +: 3]  = 3'b010;
    exp_data_q[g*2+p].push_back(exp);
    for (int i = 0; i < 20 && !accepted; i++) begin
      #1;
      if (req_ready[g][p]) begin
        accepted      = 1'b1;
        last_ready    = req_ready[g];
        last_mem_en   = mem_en[g];
        last_mem_addr = mem_addr[g];
        exp_cyc_q[g*2+p].push_back(cyc + g + 1);
      end
      @(negedge clk);
    end
    if (!accepted) begin
      num_checks++;
      num_fails++;
      $display("[TB] FAIL accept_timeout inst%0d port%0d: got no ready, required ready within 20 cycles", g, p);
    end
  endtask

  task automatic setReq(input int g, input int p, input logic valid, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[g][p]          = valid;
    req_we[g][p]             = we;
    req_addr[g][p*32 +: 32]  = addr;
    req_wdata[g][p*32 +: 32] = wdata;
    req_funct3[g][p*3 +: 3]  = 3'b010;
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < 6; i++)
      if (exp_data_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitDrain();
    for (int i = 0; i < 20 && !allEmpty(); i++) @(negedge clk);
    if (!allEmpty()) begin
      num_checks++;
      num_fails++;
      $display("[TB] FAIL drain_timeout: got pending responses, required all responses within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    int cnt0, cnt1, w;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      req_valid[g]  = '0;
      req_we[g]     = '0;
      req_addr[g]   = '0;
      req_wdata[g]  = '0;
      req_funct3[g] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      checkOutput($sformatf("reset_outputs_inst%0d", g),
                  64'({req_ready[g], rsp_valid[g], mem_en[g], mem_we[g], mem_addr[g], rsp_rdata[g]}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single read, latency 1");
    applyStimulus(0, 0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    setReq(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("single_ready", 64'(last_ready), 64'h1);
    checkOutput("single_mem_en", 64'(last_mem_en), 64'h1);
    checkOutput("single_mem_addr", 64'(last_mem_addr), 64'h10);
    waitDrain();

    $display("[TB] contention, latency 1");
    resetDut();
    for (int k = 0; k < 4; k++) begin
      exp_data_q[0].push_back({8'hA5, 24'(k)});
      exp_data_q[1].push_back({8'hA5, 24'(16 + k)});
    end
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      setReq(0, 0, cnt0 < 4, 1'b0, 32'(cnt0 * 4), 32'h0);
      setReq(0, 1, cnt1 < 4, 1'b0, 32'(32'h40 + cnt1 * 4), 32'h0);
      w = i % 2;
      #1;
      checkOutput($sformatf("contention_ready_%0d", i), 64'(req_ready[0]), (w == 0) ? 64'h1 : 64'h2);
      exp_cyc_q[w].push_back(cyc + 1);
      if (w == 0) cnt0++;
      else cnt1++;
      @(negedge clk);
    end
    setReq(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    setReq(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDrain();

    $display("[TB] back-to-back cross port, latency 2");
    setReq(1, 0, 1'b1, 1'b0, 32'h08, 32'h0);
    exp_data_q[2].push_back(32'hA5000002);
    #1;
    checkOutput("b2b_ready_t", 64'(req_ready[1]), 64'h1);
    exp_cyc_q[2].push_back(cyc + 2);
    @(negedge clk);
    setReq(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    setReq(1, 1, 1'b1, 1'b0, 32'h44, 32'h0);
    exp_data_q[3].push_back(32'hA5000011);
    #1;
    checkOutput("b2b_ready_t1", 64'(req_ready[1]), 64'h0);
    @(negedge clk);
    #1;
    checkOutput("b2b_ready_t2", 64'(req_ready[1]), 64'h2);
    checkOutput("b2b_rsp_t2", 64'(rsp_valid[1]), 64'h1);
    exp_cyc_q[3].push_back(cyc + 2);
    @(negedge clk);
    setReq(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDrain();

    $display("[TB] write then read, latency 3");
    setReq(2, 1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    exp_data_q[5].push_back(32'h0);
    #1;
    checkOutput("wr_ready_t", 64'(req_ready[2]), 64'h2);
    checkOutput("wr_mem_we_t", 64'(mem_we[2]), 64'h1);
    exp_cyc_q[5].push_back(cyc + 3);
    @(negedge clk);
    setReq(2, 1, 1'b1, 1'b0, 32'h20, 32'h0);
    exp_data_q[5].push_back(32'h12345678);
    for (int k = 1; k <= 3; k++) begin
      #1;
      checkOutput($sformatf("wr_rd_ready_t%0d", k), 64'(req_ready[2]), (k == 3) ? 64'h2 : 64'h0);
      if (k == 3) exp_cyc_q[5].push_back(cyc + 3);
      @(negedge clk);
    end
    setReq(2, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDrain();

    $display("[TB] reset during outstanding read, latency 3");
    setReq(2, 0, 1'b1, 1'b0, 32'h0C, 32'h0);
    #1;
    checkOutput("rst_ready_t", 64'(req_ready[2]), 64'h1);
    @(negedge clk);
    setReq(2, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rst_outputs_zero",
                64'({req_ready[2], rsp_valid[2], mem_en[2], mem_we[2], mem_addr[2], rsp_rdata[2]}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    setReq(2, 0, 1'b1, 1'b0, 32'h14, 32'h0);
    setReq(2, 1, 1'b1, 1'b0, 32'h18, 32'h0);
    exp_data_q[4].push_back(32'hA5000005);
    exp_data_q[5].push_back(32'hA5000006);
    #1;
    checkOutput("post_rst_contention", 64'(req_ready[2]), 64'h1);
    exp_cyc_q[4].push_back(cyc + 3);
    @(negedge clk);
    setReq(2, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      checkOutput($sformatf("post_rst_ready_t%0d", k), 64'(req_ready[2]), (k == 3) ? 64'h2 : 64'h0);
      if (k == 3) exp_cyc_q[5].push_back(cyc + 3);
      @(negedge clk);
    end
    setReq(2, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single data memory between two requesters: port 0, the core memory stage, and port 1, an external debug/loader master. Accepts at most one outstanding transaction at a time and issues it to the memory. It returns the response after a fixed memory latency. Requesters wait while their ready signal is low, so the pipeline stalls on port 0 not-ready.

## Interface
- ADDR_WIDTH, 32, address width of both ports and the memory.
- DATA_WIDTH, 32, data width.
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..4.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  2  per-port request valid; bit 0 core, bit 1 external.
- req_ready_o  out  2  per-port accept; a transfer occurs when valid&ready.
- req_we_i  in  2  per-port write enable.
- req_addr_i  in  2×ADDR_WIDTH  per-port byte address.
- req_wdata_i  in  2×DATA_WIDTH  per-port store data.
- req_funct3_i  in  2×3  per-port access size/sign (RISC-V load/store funct3).
- rsp_valid_o  out  2  one-cycle response pulse to the port that issued.
- rsp_rdata_o  out  DATA_WIDTH  response data, shared by both ports, qualified by rsp_valid_o.
- mem_en_o, mem_we_o  out  1  memory access strobe and write enable.
- mem_addr_o, mem_wdata_o, mem_funct3_o  out  ADDR_WIDTH/DATA_WIDTH/3  muxed request fields.
- mem_rdata_i  in  DATA_WIDTH  memory read data.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction outstanding; a down-counter cnt (width clog2(MEM_LATENCY)+1) counts the memory latency.
- Accept window: the FSM can accept a new request in IDLE, and in WAIT when cnt==0 (response cycle).
- Arbitration inside an accept window:
  - If exactly one port is valid, it wins.
  - If both are valid, the port not granted last wins (round-robin); last_grant updates on every accepted transfer.
- On a win, in the same cycle:
  - req_ready_o is one-hot to the winner.
  - mem_en_o is asserted.
  - The mem_* fields are driven combinationally from the winner.
  - cnt is loaded with MEM_LATENCY-1 and the FSM enters or stays in WAIT.
  - The winner's index is latched as owner.
- Outside an accept window: req_ready_o=0, mem_en_o=0, and the mem_* fields are 0.
- WAIT with cnt!=0: cnt decrements each cycle.
- WAIT with cnt==0:
  - rsp_valid_o[owner]=1 and rsp_rdata_o=mem_rdata_i. Writes also receive a response; rsp_rdata_o is then 0.
  - Next state: WAIT if a new request is accepted this cycle, else IDLE.
- Requesters must hold their fields stable while valid && !ready. The arbiter neither checks this nor checks address alignment; alignment checking is the memory's job.

## Timing
- Reset values: state=IDLE, cnt=0, owner=0, last_grant=1 (so port 0 wins the first contention), and all outputs 0.
- Latency: a request accepted at cycle t gets rsp_valid at t+MEM_LATENCY.
- Throughput: one transaction per MEM_LATENCY cycles with back-to-back requests. MEM_LATENCY=1 gives one per cycle.
- req_ready_o depends combinationally on req_valid_i and the registered state/cnt/last_grant only. It has no path from mem_rdata_i.
- Simultaneous events:
  - A response to port X and a new grant to port Y may occur in the same cycle.
  - A port may also be granted in its own response cycle.
- Fairness: a continuously valid port waits at most one transaction while the other port is also continuously valid.
- Reset mid-WAIT: the outstanding transaction is dropped with no rsp_valid. A write already strobed into memory is not undone.

## Structure
- Add to pipeline_types.svh:
  - Typedef mem_req_t {we, addr, wdata, funct3}.
  - Typedef arb_state_t {ARB_IDLE, ARB_WAIT}.
  - Constant MEM_LATENCY_MAX=4.
- One sub-module: rr_arb2, a combinational two-way round-robin picker. Inputs: valid[1:0], last_grant, enable. Outputs: one-hot grant, grant index.
- data_mem_arbiter owns the FSM, cnt, owner and last_grant registers, and the field mux.

## Test plan
- Single read, MEM_LATENCY=1: port 0 reads addr 0x10, memory returns 0xDEADBEEF → ready[0] at t, mem_en at t, rsp_valid[0] with 0xDEADBEEF at t+1, nothing on port 1.
- Contention: both ports are valid from reset with 4 requests each → grants alternate 0,1,0,1,…; 8 responses in 8 cycles, each on the correct port.
- MEM_LATENCY=3, port 1 write to 0x20 then read of 0x20 → write response at t+3 with rdata 0; read accepted at t+3; read data equals the written value at t+6; ready low during t+1..t+2.
- Back-to-back cross port, MEM_LATENCY=2: port 0 is accepted at t; port 1 is valid from t+1 → port 1 accepted at t+2 in the same cycle as rsp_valid[0]; rsp_valid[1] at t+4.
- Reset asserted at t+1 of a MEM_LATENCY=3 read → all outputs 0 immediately; no rsp_valid after reset release; the next request is accepted in IDLE with port 0 winning contention.
